// File: rtl/dram_bit_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dram_bit_reader
//  Purpose  : Reads an IO_WIDTH-bit word out of a 1-bit-wide distributed RAM
//             (asynchronous read), one bit per clock, starting at a base
//             address. Bits are assembled LSB-first and the word is handed
//             over with a valid/ready handshake.
//  Ports    : clk      - clock, all state updates on the rising edge
//             rst_n    - synchronous active-low reset
//             start    - read request, sampled only while idle
//             section  - section select (RAM A6), latched on accepted start
//             base     - start address, latched on accepted start
//             ram_out  - RAM O pin, combinational function of {sel, addr}
//             addr     - RAM address A[ADDR_WIDTH-1:0]
//             sel      - RAM section bit (A6)
//             busy     - high while reading or holding a word
//             valid    - assembled word available on data
//             ready    - consumer accepts the word when valid && ready
//             data     - assembled word, data[i] = RAM[{sel, base+i}]
//  Revision : 1.0  initial release
// ============================================================================
module dram_bit_reader #(
    parameter int IO_WIDTH   = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  section,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  ram_out,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  sel,
    output logic                  busy,
    output logic                  valid,
    input  logic                  ready,
    output logic [IO_WIDTH-1:0]   data
);

    // Bit counter must hold 0..IO_WIDTH-1; keep at least one bit for IO_WIDTH=1.
    localparam int C_CNT_W = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(IO_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  sel_q,   sel_d;
    logic [C_CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IO_WIDTH-1:0]   data_q,  data_d;
    logic                  busy_q,  busy_d;
    logic                  valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (start) begin
                    addr_d  = base;
                    sel_d   = section;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = READ;
                end
            end

            READ: begin
                // The RAM read is asynchronous, so ram_out already reflects
                // the address presented during this cycle.
                data_d[cnt_q] = ram_out;
                // Address wraps within the latched section; sel is untouched.
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (cnt_q == C_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end

            HOLD: begin
                // data and valid stay frozen until the consumer takes the word.
                if (ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign addr  = addr_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign data  = data_q;

endmodule
`default_nettype wire

// File: doc/dram_bit_reader.md
Name: dram_bit_reader

Overview:
- Reads an IO_WIDTH-bit word out of a 1-bit-wide distributed RAM (RAM64X1S/RAM128X1S class, asynchronous read), one bit per clock, starting at a requested base address.
- Assembles the bits LSB-first and presents the word with a valid/ready handshake.
- It is the read-side counterpart to the shifter that walks addresses writing switch bits into the same RAM primitive.
- It drives the RAM address and section-select pins and samples the RAM O pin.

Parameters:
IO_WIDTH, 16, bits per word read; must satisfy 1 <= IO_WIDTH <= 2**ADDR_WIDTH
ADDR_WIDTH, 6, width of the per-section RAM address (A0..A5)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  read request; sampled only in IDLE
section  input  1  section select, latched on an accepted start; drives sel (A6)
base  input  ADDR_WIDTH  start address, latched on an accepted start
ram_out  input  1  RAM O pin; asynchronous read of {sel,addr}
addr  output  ADDR_WIDTH  RAM address A[ADDR_WIDTH-1:0]
sel  output  1  RAM A6 / section bit
busy  output  1  high in READ and HOLD
valid  output  1  data word available
ready  input  1  consumer accepts the word when valid && ready
data  output  IO_WIDTH  assembled word; data[i] = RAM[{sel, base+i}]

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; addr=0, sel=0, busy=0, valid=0, data=0, bit counter=0. Applies in any state; an in-progress read is aborted and no valid is produced.
- States: IDLE, READ, HOLD.
- IDLE:
  - busy=0, valid=0.
  - On start=1: addr<=base, sel<=section, cnt<=0, go to READ.
  - start=0 holds IDLE.
- READ:
  - busy=1.
  - Each edge: data[cnt] <= ram_out; addr <= addr+1 modulo 2**ADDR_WIDTH; cnt <= cnt+1.
  - Address wrap stays inside the latched section; sel never changes mid-read.
  - On the edge where cnt==IO_WIDTH-1: capture the last bit, go to HOLD, set valid<=1.
  - addr after completion = base+IO_WIDTH (mod 2**ADDR_WIDTH) and stays there until the next accepted start.
- HOLD:
  - busy=1, valid=1.
  - data and valid are stable until the handshake.
  - On valid && ready at an edge: valid<=0, go to IDLE.
  - ready may be held high beforehand; the transfer then completes on the first HOLD edge.
- Latency: with start sampled at edge E0, valid is first high after edge E0+IO_WIDTH. Minimum repetition period is IO_WIDTH+2 cycles.
- start and base/section changes while busy are ignored. Back-to-back starts need one IDLE cycle after the handshake.
- ready while not valid is ignored.
- data is not cleared after the handshake; it retains the last word until overwritten bit-by-bit by the next read. data is meaningful only while valid=1.
- RAM WE must be held low by the integrating top while a read is in progress. This block neither drives nor checks WE.
- IO_WIDTH == 2**ADDR_WIDTH reads a whole section; addr ends back at base.

Test Plan:
(RAM128X1S with INIT=128'h96A5 repeated 8 times.)
1. Reset, then start with section=0, base=0 -> busy rises next cycle; valid rises exactly 16 edges after the start edge; data=16'h96A5; addr=16 in HOLD.
2. base=4, section=1 -> data=16'h596A. With ready held low for 5 cycles: valid and data are stable throughout; valid drops the cycle after ready=1.
3. Wrap: base=60, section=0 -> addresses 60,61,62,63,0..11 are driven in order; sel stays 0; data=16'h6A59.
4. Pulse start again during READ and HOLD, with base changed to 8 -> ignored; the returned word equals the original request. A new start in IDLE afterwards is accepted.
5. Drive rst_n low for one cycle mid-READ (after 7 bits) -> next cycle: IDLE, busy=0, valid=0, data=0, addr=0; no valid pulse follows.
6. Hold ready=1 permanently and re-issue start on the first IDLE cycle, 3 times -> three valid pulses of 1 cycle each, spaced 18 cycles apart, each data=16'h96A5.
